// File: rtl/ppf_frame_sched.sv
// ppf_frame_sched: commutates a serial sample stream into LANES-wide frames for the polyphase bank and sequences the zero-frame flush.
// Latency: frame strobe 1 cycle after the last accepted sample; out_valid_o PIPE_LAT cycles after each strobe.
// Backpressure: s_ready_o stays high in FILL (frames never stall) and is low for the whole flush sequence.
module ppf_frame_sched #(
   parameter int LANES     = 8,
   parameter int DIN_WIDTH = 32,
   parameter int TAPS      = 4,
   parameter int PIPE_LAT  = 6,
   parameter int CNT_WIDTH = 16
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       s_valid_i,
   output logic                       s_ready_o,
   input  logic [DIN_WIDTH-1:0]       s_data_i,
   input  logic                       flush_i,
   output logic [LANES*DIN_WIDTH-1:0] lane_data_o,
   output logic                       lane_valid_o,
   output logic                       out_valid_o,
   output logic [CNT_WIDTH-1:0]       frame_cnt_o,
   output logic                       busy_o,
   output logic                       flush_done_o
);

   localparam int IDX_W = (LANES > 1) ? $clog2(LANES) : 1;
   localparam int ZC_W  = (TAPS > 1) ? $clog2(TAPS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(LANES - 1);
   localparam logic [ZC_W-1:0]  LAST_ZERO = ZC_W'(TAPS - 1);

   typedef enum logic [1:0] {FILL, PAD, ZERO, WAIT} state_t;

   state_t                          state;
   logic [IDX_W-1:0]                idx;
   logic [IDX_W-1:0]                gap;
   logic [ZC_W-1:0]                 zcnt;
   logic [LANES-1:0][DIN_WIDTH-1:0] stage;
   logic [LANES-1:0][DIN_WIDTH-1:0] stage_fill;
   logic [LANES-1:0][DIN_WIDTH-1:0] lane_q;
   logic [PIPE_LAT-1:0]             occ;
   logic [PIPE_LAT-1:0]             occ_nxt;
   logic                            accept;
   logic                            last_accept;

   assign accept      = s_valid_i && s_ready_o;
   assign last_accept = accept && (idx == LAST_IDX);
   assign occ_nxt     = {occ[PIPE_LAT-2:0], lane_valid_o};
   assign out_valid_o = occ[PIPE_LAT-1];
   assign lane_data_o = lane_q;

   // Staging view with this cycle's sample already placed; first sample lands in the top lane.
   always_comb begin
      stage_fill = stage;
      if (accept) begin
         stage_fill[LAST_IDX - idx] = s_data_i;
      end
   end

   // Commutator and flush sequencer; every output it drives is registered.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state        <= FILL;
         idx          <= '0;
         gap          <= '0;
         zcnt         <= '0;
         stage        <= '0;
         lane_q       <= '0;
         lane_valid_o <= 1'b0;
         s_ready_o    <= 1'b0;
         busy_o       <= 1'b0;
         flush_done_o <= 1'b0;
      end else begin
         lane_valid_o <= 1'b0;
         flush_done_o <= 1'b0;
         case (state)
            FILL: begin
               s_ready_o <= 1'b1;
               if (last_accept) begin
                  lane_q       <= stage_fill;
                  lane_valid_o <= 1'b1;
                  stage        <= '0;
                  idx          <= '0;
               end else if (accept) begin
                  stage <= stage_fill;
                  idx   <= idx + IDX_W'(1);
               end
               // A sample arriving with the flush is absorbed first; a completed frame skips PAD.
               if (flush_i) begin
                  s_ready_o <= 1'b0;
                  busy_o    <= 1'b1;
                  gap       <= '0;
                  zcnt      <= '0;
                  if (last_accept || (!accept && idx == '0)) begin
                     state <= ZERO;
                  end else begin
                     state <= PAD;
                  end
               end
            end
            PAD: begin
               lane_q       <= stage;
               lane_valid_o <= 1'b1;
               stage        <= '0;
               idx          <= '0;
               gap          <= '0;
               state        <= ZERO;
            end
            ZERO: begin
               // Zero frames go out every LANES cycles so the bank sees the normal frame cadence.
               if (gap == LAST_IDX) begin
                  gap          <= '0;
                  lane_q       <= '0;
                  lane_valid_o <= 1'b1;
                  if (zcnt == LAST_ZERO) begin
                     state <= WAIT;
                  end else begin
                     zcnt <= zcnt + ZC_W'(1);
                  end
               end else begin
                  gap <= gap + IDX_W'(1);
               end
            end
            WAIT: begin
               // Done is flagged as the pipeline empties; ready returns the cycle after the pulse.
               if (flush_done_o) begin
                  state     <= FILL;
                  s_ready_o <= 1'b1;
                  busy_o    <= 1'b0;
               end else if (occ_nxt == '0) begin
                  flush_done_o <= 1'b1;
               end
            end
            default: begin
               state <= FILL;
            end
         endcase
      end
   end

   // Pipeline occupancy: each frame strobe walks PIPE_LAT stages to mark its DFT output.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         occ <= '0;
      end else begin
         occ <= occ_nxt;
      end
   end

   // Output frame counter, free-running modulo 2^CNT_WIDTH.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         frame_cnt_o <= '0;
      end else if (out_valid_o) begin
         frame_cnt_o <= frame_cnt_o + CNT_WIDTH'(1);
      end
   end

endmodule

// File: tb/tb_ppf_frame_sched.sv
// tb_ppf_frame_sched: directed stimulus for ppf_frame_sched with a queue-based scoreboard.
// Latency: expectations carry absolute cycle numbers for frame strobes, DFT-valid pulses and flush completion.
// Backpressure: stimulus only drives samples while s_ready_o is expected high and checks it on every send.
module tb_ppf_frame_sched;

   localparam int LANES = 8;
   localparam int DW    = 32;
   localparam int TAPS  = 4;
   localparam int PL    = 6;
   localparam int CW    = 16;
   localparam int LW    = LANES * DW;

   logic          clk_i = 1'b0;
   logic          rst_i;
   logic          s_valid_i;
   logic          s_ready_o;
   logic [DW-1:0] s_data_i;
   logic          flush_i;
   logic [LW-1:0] lane_data_o;
   logic          lane_valid_o;
   logic          out_valid_o;
   logic [CW-1:0] frame_cnt_o;
   logic          busy_o;
   logic          flush_done_o;

   ppf_frame_sched #(
      .LANES(LANES), .DIN_WIDTH(DW), .TAPS(TAPS), .PIPE_LAT(PL), .CNT_WIDTH(CW)
   ) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .s_valid_i(s_valid_i), .s_ready_o(s_ready_o), .s_data_i(s_data_i),
      .flush_i(flush_i),
      .lane_data_o(lane_data_o), .lane_valid_o(lane_valid_o),
      .out_valid_o(out_valid_o), .frame_cnt_o(frame_cnt_o),
      .busy_o(busy_o), .flush_done_o(flush_done_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct { logic [LW-1:0] dat; int cyc; } frm_t;
   typedef struct { int cyc; int cnt; } ov_t;

   frm_t          fq[$];
   ov_t           oq[$];
   int            dq[$];
   int            cyc   = 0;
   int            n_cmp = 0;
   int            n_bad = 0;
   int            m_idx = 0;
   int            m_cnt = 0;
   logic [LW-1:0] stg   = '0;

   // Cycle number: value seen between posedge n and posedge n+1.
   always @(posedge clk_i) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [LW-1:0] act, input logic [LW-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: actual %0h required %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic push_frame(input logic [LW-1:0] d, input int c);
      frm_t f;
      ov_t  o;
      f.dat = d;
      f.cyc = c;
      fq.push_back(f);
      o.cyc = c + PL;
      o.cnt = m_cnt;
      oq.push_back(o);
      m_cnt++;
   endtask

   // Flush requested in cycle t, after any sample accepted in t has been modelled.
   task automatic flush_model(input int t, output int done);
      int e;
      if (m_idx != 0) begin
         push_frame(stg, t + 2);
         e     = t + 2;
         stg   = '0;
         m_idx = 0;
      end else begin
         e = t + 1;
      end
      for (int k = 1; k <= TAPS; k++) push_frame('0, e + k * LANES);
      done = e + TAPS * LANES + PL + 1;
      dq.push_back(done);
   endtask

   task automatic send(input logic [DW-1:0] d, input logic fl, output int done);
      int t;
      s_valid_i = 1'b1;
      s_data_i  = d;
      flush_i   = fl;
      t         = cyc;
      done      = 0;
      chk("s_ready on send", LW'(s_ready_o), LW'(1));
      stg[(LANES - 1 - m_idx) * DW +: DW] = d;
      m_idx++;
      if (m_idx == LANES) begin
         push_frame(stg, t + 1);
         stg   = '0;
         m_idx = 0;
      end
      if (fl) flush_model(t, done);
      tick();
      s_valid_i = 1'b0;
      flush_i   = 1'b0;
   endtask

   task automatic flush_only(output int done);
      flush_i = 1'b1;
      flush_model(cyc, done);
      tick();
      flush_i = 1'b0;
   endtask

   task automatic flush_wait(input int done);
      while (cyc < done) begin
         chk("s_ready in flush", LW'(s_ready_o), LW'(0));
         chk("busy in flush", LW'(busy_o), LW'(1));
         tick();
      end
      chk("s_ready at done", LW'(s_ready_o), LW'(0));
      tick();
      chk("s_ready after done", LW'(s_ready_o), LW'(1));
      chk("busy after done", LW'(busy_o), LW'(0));
   endtask

   task automatic b2b();
      int c0;
      int base;
      int dn;
      c0   = cyc;
      base = m_cnt;
      for (int i = 0; i < LANES; i++) send(DW'((i + 1) << 16), 1'b0, dn);
      chk("b2b strobe", LW'(lane_valid_o), LW'(1));
      chk("b2b lane7", LW'(lane_data_o[255:224]), LW'(32'h0001_0000));
      chk("b2b lane0", LW'(lane_data_o[31:0]), LW'(32'h0008_0000));
      while (cyc < c0 + 15) tick();
      chk("b2b frame_cnt", LW'(frame_cnt_o), LW'(base + 1));
   endtask

   // Monitor: every DUT output event must match the head of its expectation queue.
   always @(negedge clk_i) begin
      if (rst_i === 1'b0) begin
         if (lane_valid_o === 1'b1) begin
            if (fq.size() == 0) chk("unexpected frame", LW'(1), LW'(0));
            else begin
               frm_t f;
               f = fq.pop_front();
               chk("frame cycle", LW'(cyc), LW'(f.cyc));
               chk("frame data", lane_data_o, f.dat);
            end
         end
         if (out_valid_o === 1'b1) begin
            if (oq.size() == 0) chk("unexpected out_valid", LW'(1), LW'(0));
            else begin
               ov_t o;
               o = oq.pop_front();
               chk("out_valid cycle", LW'(cyc), LW'(o.cyc));
               chk("frame_cnt at out", LW'(frame_cnt_o), LW'(o.cnt));
            end
         end
         if (flush_done_o === 1'b1) begin
            if (dq.size() == 0) chk("unexpected flush_done", LW'(1), LW'(0));
            else chk("flush_done cycle", LW'(cyc), LW'(dq.pop_front()));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: actual timeout required finish");
      $fatal(1, "timeout");
   end

   initial begin
      int dn;
      int t;
      int c0;
      int r;
      rst_i     = 1'b1;
      s_valid_i = 1'b1;
      s_data_i  = 32'hDEAD_BEEF;
      flush_i   = 1'b0;

      // Reset held 3 cycles with valid asserted.
      repeat (3) tick();
      chk("rst s_ready", LW'(s_ready_o), LW'(0));
      chk("rst lane_valid", LW'(lane_valid_o), LW'(0));
      chk("rst lane_data", lane_data_o, LW'(0));
      chk("rst out_valid", LW'(out_valid_o), LW'(0));
      chk("rst frame_cnt", LW'(frame_cnt_o), LW'(0));
      chk("rst busy", LW'(busy_o), LW'(0));
      chk("rst flush_done", LW'(flush_done_o), LW'(0));
      rst_i = 1'b0;
      chk("release cycle s_ready", LW'(s_ready_o), LW'(0));
      tick();
      s_valid_i = 1'b0;
      chk("first cycle after release s_ready", LW'(s_ready_o), LW'(1));

      // Back-to-back frame.
      b2b();

      // Gapped input: one sample every third cycle.
      for (int i = 0; i < 2 * LANES; i++) begin
         send(32'hA000_0000 + DW'(i * 32'h0001_0011), 1'b0, dn);
         tick();
         tick();
      end

      // Partial flush after A, B, C.
      c0 = m_cnt;
      send(32'h1111_AAAA, 1'b0, dn);
      send(32'h2222_BBBB, 1'b0, dn);
      send(32'h3333_CCCC, 1'b0, dn);
      flush_only(dn);
      chk("s_ready after flush", LW'(s_ready_o), LW'(0));
      tick();
      chk("pad strobe", LW'(lane_valid_o), LW'(1));
      chk("pad lane7", LW'(lane_data_o[255:224]), LW'(32'h1111_AAAA));
      chk("pad lane6", LW'(lane_data_o[223:192]), LW'(32'h2222_BBBB));
      chk("pad lane5", LW'(lane_data_o[191:160]), LW'(32'h3333_CCCC));
      chk("pad lanes4-0", LW'(lane_data_o[159:0]), LW'(0));
      flush_wait(dn);
      chk("frame_cnt after partial flush", LW'(frame_cnt_o), LW'(c0 + 5));

      // Aligned flush together with the 8th sample.
      for (int i = 0; i < LANES - 1; i++) send(32'h0000_5000 + DW'(i), 1'b0, dn);
      send(32'h0000_5007, 1'b1, dn);
      flush_wait(dn);

      // Reset after the second zero frame of a flush.
      send(32'h7777_0001, 1'b0, dn);
      send(32'h7777_0002, 1'b0, dn);
      t = cyc;
      flush_only(dn);
      r = t + 2 + 2 * LANES + 1;
      while (cyc < r) tick();
      rst_i = 1'b1;
      fq.delete();
      oq.delete();
      dq.delete();
      stg   = '0;
      m_idx = 0;
      m_cnt = 0;
      tick();
      rst_i = 1'b0;
      chk("midrst busy", LW'(busy_o), LW'(0));
      chk("midrst occ", LW'(dut.occ), LW'(0));
      chk("midrst out_valid", LW'(out_valid_o), LW'(0));
      chk("midrst frame_cnt", LW'(frame_cnt_o), LW'(0));
      chk("midrst lane_valid", LW'(lane_valid_o), LW'(0));
      tick();
      chk("midrst s_ready", LW'(s_ready_o), LW'(1));
      repeat (40) tick();
      b2b();

      repeat (12) tick();
      chk("frames left", LW'(fq.size()), LW'(0));
      chk("out_valid left", LW'(oq.size()), LW'(0));
      chk("flush_done left", LW'(dq.size()), LW'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
